c2_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one C2-style 4:1 data mux between four requesters.
- Drives the mux select pins A1/B1/A0/B0 so that mux S = {A1|B1, A0&B0} equals the granted index.
- Registers the selected word and presents it downstream with a valid/ready handshake.
- Sits between the four source registers and the shared result bus.

---
 rtl/c2_share_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/c2_share_arbiter.sv
// c2_share_arbiter: round-robin arbiter that shares one C2-style 4:1 mux
// between four requesters. It drives the mux select pins A1/B1/A0/B0,
// captures the selected word and hands it downstream with valid/ready.
// Optional feature macro: C2ARB_LOCK_EN (burst lock with MAX_BURST limit).
module c2_share_arbiter #(
  parameter int SIZE      = 5,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      lock,
  input  logic [SIZE-1:0] D0,
  input  logic [SIZE-1:0] D1,
  input  logic [SIZE-1:0] D2,
  input  logic [SIZE-1:0] D3,
  input  logic            out_ready,
  output logic [3:0]      gnt,
  output logic            A1,
  output logic            B1,
  output logic            A0,
  output logic            B0,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  output logic [3:0]      ack,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    XFER = 2'd2
  } state_t;

  // First set request bit scanning last+1, last+2, last+3, last; {found, index}.
  function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!res[2] && r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Pin pattern {A1,B1,A0,B0} for index k; B1 is never used.
  function automatic logic [3:0] pins_of(input logic [1:0] k);
    logic [3:0] p;
    case (k)
      2'd0:    p = 4'b0000;
      2'd1:    p = 4'b0011;
      2'd2:    p = 4'b1000;
      2'd3:    p = 4'b1011;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      gnt_r, gnt_s;
  logic [3:0]      pins_r, pins_s;
  logic [SIZE-1:0] out_data_r, out_data_s;
  logic            out_valid_r, out_valid_s;
  logic [3:0]      ack_r, ack_s;
  logic [1:0]      last_r, last_s;
  logic [1:0]      win_r, win_s;
  logic            busy_r;

  logic [2:0]      idle_pick_s;
  logic [2:0]      next_pick_s;
  logic [1:0]      mux_sel_s;
  logic [SIZE-1:0] mux_out_s;
  logic            xfer_done_s;
  logic            regrant_s;

  assign idle_pick_s = pick_winner(req, last_r);
  // The requester just acknowledged may still hold req high; exclude it.
  assign next_pick_s = pick_winner(req & ~gnt_r, last_r);
  assign xfer_done_s = (state_r == XFER) && out_valid_r && out_ready;

  // Internal copy of the C2 mux: S = {A1|B1, A0&B0}, same as the external cell.
  always_comb begin
    mux_sel_s = {pins_r[3] | pins_r[2], pins_r[1] & pins_r[0]};
    case (mux_sel_s)
      2'd0:    mux_out_s = D0;
      2'd1:    mux_out_s = D1;
      2'd2:    mux_out_s = D2;
      2'd3:    mux_out_s = D3;
      default: mux_out_s = D0;
    endcase
  end

`ifdef C2ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST) + 1;
  logic [BW-1:0] burst_r, burst_s;

  // Locked requester keeps the mux while its burst budget lasts.
  always_comb begin
    if (lock[win_r] && req[win_r] && (int'(burst_r) < (MAX_BURST - 1))) begin
      regrant_s = 1'b1;
    end else begin
      regrant_s = 1'b0;
    end
  end

  // Burst counter: counts locked re-grants, clears on IDLE or a new owner.
  always_comb begin
    burst_s = burst_r;
    if (state_r == IDLE) begin
      burst_s = '0;
    end else if (xfer_done_s) begin
      if (regrant_s) begin
        burst_s = burst_r + BW'(1);
      end else begin
        burst_s = '0;
      end
    end else begin
      burst_s = burst_r;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_r <= '0;
    end else begin
      burst_r <= burst_s;
    end
  end
`else
  logic unused_lock_s;
  localparam int unused_max_burst_lp = MAX_BURST;
  assign unused_lock_s = ^lock;
  assign regrant_s     = 1'b0;
`endif

  // Sequencer next-state and output decode.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    pins_s      = pins_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    ack_s       = 4'b0000;
    last_s      = last_r;
    win_s       = win_r;
    case (state_r)
      IDLE: begin
        if (idle_pick_s[2]) begin
          state_s = SEL;
          win_s   = idle_pick_s[1:0];
          gnt_s   = 4'b0001 << idle_pick_s[1:0];
          pins_s  = pins_of(idle_pick_s[1:0]);
        end else begin
          state_s = IDLE;
        end
      end
      SEL: begin
        out_data_s  = mux_out_s;
        out_valid_s = 1'b1;
        last_s      = win_r;
        state_s     = XFER;
      end
      XFER: begin
        if (xfer_done_s) begin
          ack_s       = gnt_r;
          out_valid_s = 1'b0;
          if (regrant_s) begin
            state_s = SEL;
          end else if (next_pick_s[2]) begin
            state_s = SEL;
            win_s   = next_pick_s[1:0];
            gnt_s   = 4'b0001 << next_pick_s[1:0];
            pins_s  = pins_of(next_pick_s[1:0]);
          end else begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            pins_s  = 4'b0000;
          end
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = 4'b0000;
        pins_s      = 4'b0000;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset discards any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      gnt_r       <= 4'b0000;
      pins_r      <= 4'b0000;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      ack_r       <= 4'b0000;
      last_r      <= 2'd3;
      win_r       <= 2'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      pins_r      <= pins_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      ack_r       <= ack_s;
      last_r      <= last_s;
      win_r       <= win_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign gnt       = gnt_r;
  assign A1        = pins_r[3];
  assign B1        = pins_r[2];
  assign A0        = pins_r[1];
  assign B0        = pins_r[0];
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign ack       = ack_r;
  assign busy      = busy_r;

endmodule
